// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle sequencer for the HI/LO multiply/divide resource in EX.
//   MULT/MULTU complete a fixed MUL_CYCLES edges after acceptance. DIV/DIVU run
//   a 32-step restoring divide on magnitudes followed by one sign-fix edge.
//   MTHI/MTLO write HI/LO directly in IDLE without a done pulse.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous active-high reset
//   op_valid  in   1   EX presents an HI/LO op
//   op        in   3   0=none 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO (7 ignored)
//   a, b      in   32  rs / rt operands
//   op_ready  out  1   unit idle, op can be accepted
//   mf_req    in   1   MFHI/MFLO in EX this cycle
//   flush     in   1   abort the in-flight op; blocks acceptance in IDLE
//   stall     out  1   hold the pipeline (busy and a new op / MF arrives)
//   busy      out  1   mul/div in flight
//   done      out  1   one-cycle pulse when a new HI/LO result is visible
//   hi_o,lo_o out  32  architectural HI / LO
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        op_ready,
    input  logic        mf_req,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES);
    localparam logic [4:0] DIV_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    // r_opa: multiplicand, or dividend magnitude shifting into the quotient.
    // r_opb: multiplier, or divisor magnitude.
    logic [31:0] r_opa;
    logic [31:0] r_opb;
    logic [31:0] r_rem;
    logic        r_mul_signed;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_idle;
    logic        w_accept;
    logic        w_div_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_idle   = (r_state == ST_IDLE);
    // flush also blocks acceptance so a squashed instruction never issues.
    assign w_accept = op_valid & w_idle & ~flush & (op >= OP_MULT) & (op <= OP_MTLO);

    assign w_div_signed = (op == OP_DIV);
    // Magnitude of 0x80000000 stays 0x80000000, which is correct read as unsigned.
    assign w_abs_a = (w_div_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b = (w_div_signed && b[31]) ? (32'd0 - b) : b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are the
    // same whether the multiply is interpreted as signed or unsigned.
    assign w_mul_a   = {{32{r_mul_signed & r_opa[31]}}, r_opa};
    assign w_mul_b   = {{32{r_mul_signed & r_opb[31]}}, r_opb};
    assign w_product = w_mul_a * w_mul_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The partial remainder is
    // always below the divisor, so a non-negative difference fits in 32 bits.
    assign w_shift = {r_rem, r_opa[31]};
    assign w_diff  = w_shift - {1'b0, r_opb};

    always_comb begin
        w_rem_next = w_shift[31:0];
        w_quo_next = {r_opa[30:0], 1'b0};
        if (!w_diff[32]) begin
            w_rem_next = w_diff[31:0];
            w_quo_next = {r_opa[30:0], 1'b1};
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op == OP_MULT || op == OP_MULTU) begin
                        w_state_next = ST_MUL;
                    end else if ((op == OP_DIV || op == OP_DIVU) && b != 32'd0) begin
                        w_state_next = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                if (flush || r_cnt == MUL_LAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == DIV_LAST) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 5'd0;
            r_opa        <= 32'd0;
            r_opb        <= 32'd0;
            r_rem        <= 32'd0;
            r_mul_signed <= 1'b0;
            r_neg_q      <= 1'b0;
            r_neg_r      <= 1'b0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_opa        <= a;
                                r_opb        <= b;
                                r_mul_signed <= (op == OP_MULT);
                                r_cnt        <= 5'd1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (b == 32'd0) begin
                                    // Divide by zero: HI/LO untouched, just signal completion.
                                    r_done <= 1'b1;
                                end else begin
                                    r_opa   <= w_abs_a;
                                    r_opb   <= w_abs_b;
                                    r_rem   <= 32'd0;
                                    r_neg_q <= w_div_signed & (a[31] ^ b[31]);
                                    r_neg_r <= w_div_signed & a[31];
                                    r_cnt   <= 5'd0;
                                end
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == MUL_LAST) begin
                            r_hi   <= w_product[63:32];
                            r_lo   <= w_product[31:0];
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_DIV: begin
                    if (!flush) begin
                        r_opa <= w_quo_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        r_lo   <= r_neg_q ? (32'd0 - r_opa) : r_opa;
                        r_hi   <= r_neg_r ? (32'd0 - r_rem) : r_rem;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_ready = w_idle;
    assign busy     = ~w_idle;
    assign stall    = ~w_idle & (op_valid | mf_req);
    assign done     = r_done;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        op_ready;
    logic        mf_req;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          nbusy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_seq #(.MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .op_ready(op_ready), .mf_req(mf_req), .flush(flush), .stall(stall),
        .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Reference result {hi,lo} using 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] res;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        res = {m_hi, m_lo};
        case (o)
            3'd1: res = 64'(sx * sy);
            3'd2: res = {32'd0, x} * {32'd0, y};
            3'd3: if (y != 32'd0) begin
                      q   = sx / sy;
                      r   = sx % sy;
                      res = {r[31:0], q[31:0]};
                  end
            3'd4: if (y != 32'd0) res = {x % y, x / y};
            3'd5: res = {x, m_lo};
            3'd6: res = {m_hi, x};
            default: ;
        endcase
        return res;
    endfunction

    // Drive one op for a single edge; ends 1ns after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit commit);
        exp_t        e;
        logic [63:0] r;
        if (commit) begin
            r = model(o, x, y);
            if (o >= 3'd1 && o <= 3'd4) begin
                e.hi    = r[63:32];
                e.lo    = r[31:0];
                e.lat   = (o <= 3'd2) ? 5 : ((y == 32'd0) ? 1 : 34);
                e.nbusy = (o <= 3'd2) ? 4 : ((y == 32'd0) ? 0 : 33);
                sb.push_back(e);
            end
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        op_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    // Count negedges until done; reports latency, busy cycles and timeout.
    task automatic wait_done(output int lat, output int nbusy, output bit to);
        lat   = 0;
        nbusy = 0;
        to    = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (hi_o !== 32'd0)   begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
        checks++; if (lo_o !== 32'd0)   begin errors++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
        $display("txn reset hi=%h lo=%h busy=%b", hi_o, lo_o, busy);
    endtask

    task automatic test_arith();
        logic [2:0]  ops[9];
        logic [31:0] av[9];
        logic [31:0] bv[9];
        int   lat;
        int   nb;
        bit   to;
        exp_t e;
        ops = '{3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd2, 3'd1, 3'd3, 3'd4};
        av  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd99,
                32'hFFFFFFFF, 32'h80000000, 32'd7, 32'hFFFFFFFF};
        bv  = '{32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0,
                32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'd10};
        for (int i = 0; i < 15; i++) begin
            logic [2:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            if (i < 9) begin
                o = ops[i]; x = av[i]; y = bv[i];
            end else begin
                o = 3'($urandom_range(1, 4)); x = $urandom; y = $urandom;
            end
            issue(o, x, y, 1'b1);
            wait_done(lat, nb, to);
            e = sb.pop_front();
            checks++;
            if (to) begin
                errors++; $display("FAIL arith_timeout idx=%0d op=%0d no done within 60 cycles", i, o);
            end else begin
                if (hi_o !== e.hi) begin errors++; $display("FAIL arith_hi idx=%0d got=%h exp=%h", i, hi_o, e.hi); end
                checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL arith_lo idx=%0d got=%h exp=%h", i, lo_o, e.lo); end
                checks++; if (lat != e.lat)  begin errors++; $display("FAIL arith_latency idx=%0d got=%0d exp=%0d", i, lat, e.lat); end
                checks++; if (nb != e.nbusy) begin errors++; $display("FAIL arith_busy_cycles idx=%0d got=%0d exp=%0d", i, nb, e.nbusy); end
                @(negedge clk);
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL arith_done_width idx=%0d got=%b exp=0", i, done); end
            end
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", o, x, y, hi_o, lo_o, lat);
        end
    endtask

    task automatic test_mf_stall();
        int   n = 0;
        int   nstall = 0;
        bit   seen = 1'b0;
        exp_t e;
        issue(3'd3, 32'd1000, 32'hFFFFFFF9, 1'b1);
        e = sb.pop_front();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n++;
            if (done) begin seen = 1'b1; break; end
            if (n == 5) mf_req = 1'b1;
            #1;
            if (stall === 1'b1) nstall++;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mf_timeout no done within 60 cycles"); end
        checks++; if (nstall != 29) begin errors++; $display("FAIL mf_stall_cycles got=%0d exp=29", nstall); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mf_stall_at_done got=%b exp=0", stall); end
        checks++; if (hi_o !== e.hi) begin errors++; $display("FAIL mf_hi got=%h exp=%h", hi_o, e.hi); end
        checks++; if (lo_o !== e.lo) begin errors++; $display("FAIL mf_lo got=%h exp=%h", lo_o, e.lo); end
        checks++; if (n != 34) begin errors++; $display("FAIL mf_latency got=%0d exp=34", n); end
        mf_req = 1'b0;
        $display("txn mf_stall stall_cycles=%0d hi=%h lo=%h", nstall, hi_o, lo_o);
    endtask

    task automatic test_flush();
        int ndone = 0;
        issue(3'd5, 32'h0000AAAA, 32'd0, 1'b1);
        issue(3'd6, 32'h00005555, 32'd0, 1'b1);
        issue(3'd3, 32'd1000, 32'd3, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL flush_done_pulses got=%0d exp=0", ndone); end
        checks++; if (hi_o !== m_hi) begin errors++; $display("FAIL flush_hi got=%h exp=%h", hi_o, m_hi); end
        checks++; if (lo_o !== m_lo) begin errors++; $display("FAIL flush_lo got=%h exp=%h", lo_o, m_lo); end
        // flush while idle squashes the presented op
        flush = 1'b1;
        issue(3'd6, 32'h0000DEAD, 32'd0, 1'b0);
        flush = 1'b0;
        checks++; if (lo_o !== m_lo) begin errors++; $display("FAIL flush_idle_lo got=%h exp=%h", lo_o, m_lo); end
        $display("txn flush hi=%h lo=%h done_pulses=%0d", hi_o, lo_o, ndone);
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        issue(3'd1, 32'd12345, 32'd678, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", hi_o); end
        checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", lo_o); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        issue(3'd6, 32'h00001234, 32'd0, 1'b1);
        checks++; if (lo_o !== 32'h00001234) begin errors++; $display("FAIL mtlo_lo got=%h exp=00001234", lo_o); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done got=%b exp=0", done); end
        checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL mtlo_hi got=%h exp=0", hi_o); end
        $display("txn rst_mid then MTLO hi=%h lo=%h", hi_o, lo_o);
    endtask

    task automatic test_ignored_op();
        issue(3'd7, 32'hFFFF0000, 32'd1, 1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op7_busy got=%b exp=0", busy); end
        checks++; if ({hi_o, lo_o} !== {m_hi, m_lo}) begin errors++; $display("FAIL op7_hilo got=%h%h exp=%h%h", hi_o, lo_o, m_hi, m_lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL op7_done got=%b exp=0", done); end
        $display("txn op7 ignored hi=%h lo=%h", hi_o, lo_o);
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   nb;
        bit   to;
        exp_t e;
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(lat, nb, to);
        e = sb.pop_front();
        checks++; if (to || hi_o !== e.hi || lo_o !== e.lo) begin errors++; $display("FAIL b2b_first got=%h%h exp=%h%h to=%b", hi_o, lo_o, e.hi, e.lo, to); end
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got=%b exp=1", op_ready); end
        $display("txn b2b MULTU hi=%h lo=%h", hi_o, lo_o);
        issue(3'd4, 32'd100, 32'd7, 1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
        wait_done(lat, nb, to);
        e = sb.pop_front();
        checks++; if (to || hi_o !== e.hi || lo_o !== e.lo) begin errors++; $display("FAIL b2b_second got=%h%h exp=%h%h to=%b", hi_o, lo_o, e.hi, e.lo, to); end
        checks++; if (lat != 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        $display("txn b2b DIVU hi=%h lo=%h lat=%0d", hi_o, lo_o, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        a        = 32'd0;
        b        = 32'd0;
        mf_req   = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_arith();
        test_mf_stall();
        test_flush();
        test_rst_mid();
        test_ignored_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
